// File: rtl/riscv_pkg.sv
// Shared core definitions for the RV32M multiply/divide unit: widths,
// funct3 encodings, FSM state type and operand-signedness helpers.
package riscv_pkg;

   localparam int XLEN  = 32;
   localparam int CNT_W = 6;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      MD_IDLE  = 2'd0,
      MD_CALC  = 2'd1,
      MD_FIXUP = 2'd2,
      MD_DONE  = 2'd3
   } md_state_e;

   function automatic logic is_div_op(input logic [2:0] f3);
      return f3[2];
   endfunction

   function automatic logic op_a_signed(input logic [2:0] f3);
      return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

   function automatic logic op_b_signed(input logic [2:0] f3);
      return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// One-bit-per-cycle shift-add multiplier / restoring divider on operand
// magnitudes. The 64-bit acc holds {hi, lo}: product, or {remainder, quotient}.
module muldiv_datapath #(
   parameter int XLEN = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              step,
   input  logic              is_div,
   input  logic [XLEN-1:0]   mag_a,
   input  logic [XLEN-1:0]   mag_b,
   output logic [2*XLEN-1:0] acc
);

   logic [2*XLEN-1:0] acc_reg;
   logic [2*XLEN-1:0] acc_next;
   logic [XLEN-1:0]   opb_reg;
   logic [XLEN:0]     add_sum;
   logic [XLEN:0]     rem_shift;
   logic [XLEN:0]     rem_diff;

   always_comb begin
      // Multiply: lo starts as the multiplier and is consumed LSB-first while
      // the partial product shifts in from the top.
      add_sum   = {1'b0, acc_reg[2*XLEN-1:XLEN]} + {1'b0, (acc_reg[0] ? opb_reg : {XLEN{1'b0}})};
      // Divide: remainder shifted left with the next dividend bit; bit XLEN of
      // the difference is the borrow, so it alone decides restore vs. keep.
      rem_shift = acc_reg[2*XLEN-1:XLEN-1];
      rem_diff  = rem_shift - {1'b0, opb_reg};
      acc_next  = acc_reg;
      if (load) begin
         acc_next = {{XLEN{1'b0}}, mag_a};
      end else if (step) begin
         if (is_div) begin
            if (!rem_diff[XLEN]) begin
               acc_next = {rem_diff[XLEN-1:0], acc_reg[XLEN-2:0], 1'b1};
            end else begin
               acc_next = {rem_shift[XLEN-1:0], acc_reg[XLEN-2:0], 1'b0};
            end
         end else begin
            acc_next = {add_sum, acc_reg[XLEN-1:1]};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_reg <= '0;
         opb_reg <= '0;
      end else begin
         acc_reg <= acc_next;
         if (load) begin
            opb_reg <= mag_b;
         end
      end
   end

   assign acc = acc_reg;

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative RV32M unit: accepts an op from IDLE, iterates 32 cycles,
// applies signs in FIXUP and pulses done. Divide special cases finish at once.
import riscv_pkg::*;

module ex_muldiv_unit #(
   parameter int XLEN  = riscv_pkg::XLEN,
   parameter int CNT_W = riscv_pkg::CNT_W
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic            flush,
   output logic [XLEN-1:0] result,
   output logic            done,
   output logic            busy,
   output logic            stall
);

   localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

   md_state_e         state_reg;
   logic [CNT_W-1:0]  cnt_reg;
   logic [2:0]        f3_reg;
   logic              neg_a_reg;
   logic              neg_b_reg;
   logic [XLEN-1:0]   result_reg;
   logic              done_reg;

   logic              accept;
   logic              neg_a;
   logic              neg_b;
   logic [XLEN-1:0]   mag_a;
   logic [XLEN-1:0]   mag_b;
   logic              div_zero;
   logic              div_ovf;
   logic [XLEN-1:0]   special_result;
   logic [2*XLEN-1:0] acc;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quot;
   logic [XLEN-1:0]   rem;
   logic [XLEN-1:0]   fix_result;

   assign accept = (state_reg == MD_IDLE) && start && !flush;

   always_comb begin
      neg_a    = op_a_signed(funct3) && op_a[XLEN-1];
      neg_b    = op_b_signed(funct3) && op_b[XLEN-1];
      mag_a    = neg_a ? (~op_a + 1'b1) : op_a;
      mag_b    = neg_b ? (~op_b + 1'b1) : op_b;
      div_zero = is_div_op(funct3) && (op_b == '0);
      div_ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                 (op_a == MIN_NEG) && (op_b == ALL_ONES);
      // funct3[1] separates REM/REMU from DIV/DIVU
      special_result = '0;
      if (div_zero) begin
         special_result = funct3[1] ? op_a : ALL_ONES;
      end else if (div_ovf) begin
         special_result = funct3[1] ? '0 : MIN_NEG;
      end
   end

   muldiv_datapath #(
      .XLEN(XLEN)
   ) u_datapath (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (accept),
      .step   ((state_reg == MD_CALC) && !flush),
      .is_div (is_div_op(f3_reg)),
      .mag_a  (mag_a),
      .mag_b  (mag_b),
      .acc    (acc)
   );

   always_comb begin
      // The latched sign flags already encode MULHSU (neg_b is never set).
      prod = (neg_a_reg ^ neg_b_reg) ? (~acc + 1'b1) : acc;
      quot = (neg_a_reg ^ neg_b_reg) ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
      rem  = neg_a_reg ? (~acc[2*XLEN-1:XLEN] + 1'b1) : acc[2*XLEN-1:XLEN];
      case (f3_reg)
         F3_MUL:                       fix_result = prod[XLEN-1:0];
         F3_MULH, F3_MULHSU, F3_MULHU: fix_result = prod[2*XLEN-1:XLEN];
         F3_DIV, F3_DIVU:              fix_result = quot;
         default:                      fix_result = rem;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= MD_IDLE;
         cnt_reg    <= '0;
         f3_reg     <= '0;
         neg_a_reg  <= 1'b0;
         neg_b_reg  <= 1'b0;
         result_reg <= '0;
         done_reg   <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         if (flush) begin
            state_reg <= MD_IDLE;
         end else begin
            case (state_reg)
               MD_IDLE: begin
                  if (start) begin
                     f3_reg    <= funct3;
                     neg_a_reg <= neg_a;
                     neg_b_reg <= neg_b;
                     cnt_reg   <= '0;
                     if (div_zero || div_ovf) begin
                        result_reg <= special_result;
                        done_reg   <= 1'b1;
                        state_reg  <= MD_DONE;
                     end else begin
                        state_reg <= MD_CALC;
                     end
                  end
               end
               MD_CALC: begin
                  cnt_reg <= cnt_reg + 1'b1;
                  if (cnt_reg == LAST_ITER) begin
                     state_reg <= MD_FIXUP;
                  end
               end
               MD_FIXUP: begin
                  result_reg <= fix_result;
                  done_reg   <= 1'b1;
                  state_reg  <= MD_DONE;
               end
               default: begin
                  state_reg <= MD_IDLE;
               end
            endcase
         end
      end
   end

   assign result = result_reg;
   assign done   = done_reg;
   assign busy   = (state_reg == MD_CALC) || (state_reg == MD_FIXUP);
   assign stall  = accept || busy;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Table-driven and scoreboard-checked bench for ex_muldiv_unit, plus flush,
// reset and random sequences checked against a behavioural RV32M model.
module tb_ex_muldiv_unit;

   localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
   localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [2:0]  funct3;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        flush;
   logic [31:0] result;
   logic        done;
   logic        busy;
   logic        stall;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   logic [31:0] last_exp = 32'h0;

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   typedef struct {
      logic [31:0] res;
      int          cyc;
   } exp_t;

   vec_t vecs[19];
   exp_t sb_q[$];

   ex_muldiv_unit dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .funct3 (funct3),
      .op_a   (op_a),
      .op_b   (op_b),
      .flush  (flush),
      .result (result),
      .done   (done),
      .busy   (busy),
      .stall  (stall)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %h want %h", nm, got, want);
      end else begin
         $display("[TB] ok   %s = %h", nm, got);
      end
   endtask

   function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      logic signed [31:0] sa;
      logic signed [31:0] sb;
      sa = a;
      sb = b;
      case (f3)
         MUL:    begin p = {32'h0, a} * {32'h0, b};             return p[31:0];  end
         MULH:   begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
         MULHSU: begin p = {{32{a[31]}}, a} * {32'h0, b};       return p[63:32]; end
         MULHU:  begin p = {32'h0, a} * {32'h0, b};             return p[63:32]; end
         DIV:    begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            return 32'(sa / sb);
         end
         DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
         REM:    begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            return 32'(sa % sb);
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   // Issues one op, scoreboards the expected result and done cycle, then
   // waits (bounded) for done and checks stall/busy across the op.
   task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat, input string nm);
      exp_t e;
      bit   seen;
      bit   stall_ok;
      @(posedge clk); #1;
      start = 1'b1; funct3 = f3; op_a = a; op_b = b;
      @(negedge clk);
      check({nm, " stall_accept"}, {63'h0, stall}, 64'h1);
      @(posedge clk); #1;
      e.res = exp;
      e.cyc = cyc + lat - 1;
      sb_q.push_back(e);
      start = 1'b0; funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom;
      seen = 1'b0;
      stall_ok = 1'b1;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            e = sb_q.pop_front();
            check({nm, " result"}, {32'h0, result}, {32'h0, e.res});
            check({nm, " done_cycle"}, 64'(cyc), 64'(e.cyc));
            check({nm, " stall_on_done"}, {63'h0, stall}, 64'h0);
         end else if (!stall || !busy) begin
            stall_ok = 1'b0;
         end
      end
      if (!seen) begin
         tests++;
         fails++;
         $display("FAIL %s timeout: got no done want done", nm);
         sb_q.delete();
      end
      check({nm, " stall_busy_inflight"}, {63'h0, stall_ok}, 64'h1);
      @(negedge clk);
      check({nm, " done_pulse"}, {63'h0, done}, 64'h0);
      last_exp = exp;
   endtask

   task automatic expect_no_done(input int n, input string nm);
      bit got_done;
      got_done = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (done) got_done = 1'b1;
      end
      check(nm, {63'h0, got_done}, 64'h0);
   endtask

   initial begin
      vecs[0]  = '{MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
      vecs[1]  = '{MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
      vecs[2]  = '{MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34};
      vecs[3]  = '{MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 34};
      vecs[4]  = '{DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34};
      vecs[5]  = '{REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34};
      vecs[6]  = '{DIVU,   32'd100,       32'd7,         32'd14,        34};
      vecs[7]  = '{REMU,   32'd100,       32'd7,         32'd2,         34};
      vecs[8]  = '{DIVU,   32'h1234,      32'd0,         32'hFFFF_FFFF, 1};
      vecs[9]  = '{REM,    32'h1234,      32'd0,         32'h1234,      1};
      vecs[10] = '{DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
      vecs[11] = '{REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
      vecs[12] = '{MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34};
      vecs[13] = '{DIVU,   32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 34};
      vecs[14] = '{REMU,   32'd5,         32'd0,         32'd5,         1};
      vecs[15] = '{DIV,    32'h8000_0000, 32'd2,         32'hC000_0000, 34};
      vecs[16] = '{DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 34};
      vecs[17] = '{REM,    32'd7,         32'hFFFF_FFFE, 32'd1,         34};
      vecs[18] = '{DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         34};

      rst_n = 1'b0; start = 1'b0; funct3 = 3'b0; op_a = '0; op_b = '0; flush = 1'b0;
      repeat (2) @(negedge clk);
      check("reset result", {32'h0, result}, 64'h0);
      check("reset done",   {63'h0, done},   64'h0);
      check("reset busy",   {63'h0, busy},   64'h0);
      rst_n = 1'b1;

      for (int i = 0; i < 19; i++) begin
         run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, $sformatf("vec%0d", i));
      end

      // start together with flush in IDLE must not be accepted
      @(posedge clk); #1;
      start = 1'b1; flush = 1'b1; funct3 = MUL; op_a = 32'd9; op_b = 32'd9;
      @(negedge clk);
      check("start_flush stall", {63'h0, stall}, 64'h0);
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      @(negedge clk);
      check("start_flush busy", {63'h0, busy}, 64'h0);

      // flush at iteration 10 of MUL 5*6
      @(posedge clk); #1;
      start = 1'b1; funct3 = MUL; op_a = 32'd5; op_b = 32'd6;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      check("flush busy",   {63'h0, busy},   64'h0);
      check("flush done",   {63'h0, done},   64'h0);
      check("flush result", {32'h0, result}, {32'h0, last_exp});
      expect_no_done(40, "flush no_done");
      run_op(MUL, 32'd3, 32'd4, 32'd12, 34, "after_flush");

      // async reset mid-CALC
      @(posedge clk); #1;
      start = 1'b1; funct3 = MUL; op_a = 32'd9; op_b = 32'd9;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midreset result", {32'h0, result}, 64'h0);
      check("midreset busy",   {63'h0, busy},   64'h0);
      check("midreset stall",  {63'h0, stall},  64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      expect_no_done(40, "midreset no_done");
      run_op(DIVU, 32'd100, 32'd7, 32'd14, 34, "after_reset");

      for (int i = 0; i < 12; i++) begin
         logic [2:0]  f3;
         logic [31:0] a;
         logic [31:0] b;
         int          lat;
         f3 = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
         if (i == 11) b = 32'h0;
         lat = (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 1 : 34;
         run_op(f3, a, b, model(f3, a, b), lat, $sformatf("rand%0d", i));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
Iterative RV32M multiply/divide unit in the EX stage of the 5-stage core. It consumes the forwarded operands produced by the EX-stage operand-select muxes, in parallel with the ALU. It computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU with a radix-2 shift-add / restoring-divide datapath. It raises a stall to the hazard logic while an operation is in flight.

Parameters:
XLEN, 32, operand/result width; only 32 is supported.
CNT_W, 6, iteration-counter width; must hold XLEN.

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  EX holds a valid M-extension instruction
funct3  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op_a  input  XLEN  rs1 value after forwarding mux
op_b  input  XLEN  rs2 value after forwarding mux
flush  input  1  pipeline flush (branch/exception); aborts the current op
result  output  XLEN  final result, valid while done=1
done  output  1  one-cycle pulse: result valid
busy  output  1  operation in flight (CALC or FIXUP)
stall  output  1  combinational stall request to the hazard unit

Behaviour:
- Reset (rst_n=0, async): state=IDLE; result=0, done=0, busy=0; counter and internal registers cleared. Reset mid-operation discards the op with no done.
- States: IDLE, CALC, FIXUP, DONE.
- IDLE: start=1 and flush=0 at an edge accepts the op. Accept latches funct3 and the operand magnitudes and signs:
  - signed for MULH and DIV/REM;
  - op_a signed, op_b unsigned for MULHSU;
  - unsigned otherwise.
- Accept transitions:
  - op_b==0 on a divide-class op: go directly to DONE.
  - op_a==0x80000000, op_b==0xFFFFFFFF on DIV/REM: go directly to DONE.
  - otherwise: go to CALC with counter=0.
- CALC: one iteration per cycle for exactly XLEN (32) cycles.
  - Multiply: 64-bit accumulator, shift-add on magnitudes.
  - Divide: restoring shift-subtract yielding quotient and remainder magnitudes.
  - counter==XLEN-1: go to FIXUP.
- FIXUP (1 cycle): apply signs.
  - Product is negated if the operand signs differ (MULHSU: if op_a is negative).
  - Quotient is negated if the signs differ; remainder takes the dividend's sign.
  - Selects low word (MUL), high word (MULH*), quotient, or remainder. Go to DONE.
- DONE (1 cycle): done=1, result driven; go to IDLE.
- result holds its value after DONE until the next DONE.
- Latency: normal op has done high in the 34th cycle after the accept edge (32 CALC + FIXUP + DONE). Special cases have done high in the cycle after the accept edge.
- Special-case results (RISC-V spec):
  - divide by zero: DIV/DIVU quotient=0xFFFFFFFF; REM/REMU remainder=op_a.
  - signed overflow: DIV=0x80000000; REM=0.
- stall = (state==IDLE && start && !flush) || state==CALC || state==FIXUP. stall is low in DONE so the pipeline advances on the done cycle.
- busy = (state==CALC || state==FIXUP).
- start while not IDLE is ignored. EX holds start/operands stable while stalled; the unit does not rely on this after accept.
- flush in any state: next state IDLE, no done pulse, result unchanged. flush and start together in IDLE: not accepted.
- Start in the DONE cycle is not accepted. The pipeline has advanced, so a back-to-back M-op is accepted from IDLE on the following cycle.
- All arithmetic is unsigned on magnitudes with 2's-complement fixup. Negating 0x80000000 magnitude yields 0x80000000 (wraps correctly).

Decomposition:
- Shared core package (riscv_pkg): funct3 constants for the M extension, a state enum typedef, and XLEN.
- One natural sub-module: muldiv_datapath (accumulator/remainder/quotient registers and one-step shift-add/subtract). The FSM, sign handling and stall logic stay in ex_muldiv_unit.

Test Plan:
1. MUL op_a=7, op_b=0xFFFFFFFD (-3) -> result 0xFFFFFFEB at cycle 34 after accept; stall high for cycles 0..33, low on the done cycle.
2. MULHU op_a=op_b=0xFFFFFFFF -> 0xFFFFFFFE; MULH with same operands -> 0x00000000; MULHSU op_a=0xFFFFFFFF, op_b=2 -> 0xFFFFFFFF.
3. DIV op_a=0xFFFFFFF9 (-7), op_b=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
4. DIVU op_a=0x1234, op_b=0 -> 0xFFFFFFFF with done one cycle after accept; REM op_a=0x1234, op_b=0 -> 0x1234.
5. DIV op_a=0x80000000, op_b=0xFFFFFFFF -> 0x80000000; REM same operands -> 0, both fast path.
6. MUL 5*6 with flush asserted at iteration 10 -> no done, busy low next cycle, result unchanged. New MUL 3*4 accepted after flush -> 12. rst_n pulsed mid-CALC -> outputs 0 immediately.
